// File: rtl/lcd_num_formatter_pkg.sv
// Shared types and constants for the LCD number formatter.
// Also holds the helper that turns a sign and five BCD digits into one display line.
package lcd_num_formatter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FORMAT,
    COMMIT
  } state_t;

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [7:0] MINUS      = 8'h2D;
  localparam logic [7:0] ZERO       = 8'h30;
  localparam int         LINE_CHARS = 16;

  // Line layout: label (2), sign (1), five digits with leading blanks (5), padding (8).
  function automatic logic [8*LINE_CHARS-1:0] format_line(input logic [15:0] label,
                                                          input logic        neg,
                                                          input logic [19:0] bcd);
    logic [8*LINE_CHARS-1:0] l;
    logic [3:0]              d;
    logic                    seen;
    l          = {LINE_CHARS{SPACE}};
    l[127:120] = label[15:8];
    l[119:112] = label[7:0];
    l[111:104] = neg ? MINUS : SPACE;
    seen       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = bcd[19-4*i -: 4];
      if (d != 4'd0 || i == 4) seen = 1'b1;
      if (seen) l[103-8*i -: 8] = ZERO + {4'h0, d};
    end
    return l;
  endfunction

endpackage

// File: rtl/lcd_num_formatter_bcd_dabble16.sv
// Sequential double-dabble: 16-bit binary to five BCD digits, one bit per step.
// load clears the BCD register and latches the operand; 16 steps complete a conversion.
module bcd_dabble16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] bin,
  output logic [19:0] bcd
);

  logic [15:0] mag_q;
  logic [19:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q <= '0;
      bcd   <= '0;
    end else if (load) begin
      mag_q <= bin;
      bcd   <= '0;
    end else if (step) begin
      bcd   <= {adj[18:0], mag_q[15]};
      mag_q <= {mag_q[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/lcd_num_formatter.sv
// Converts two signed 16-bit values into two 16-character LCD lines.
// Both lines are committed together so the display never shows a half-updated pair.
module lcd_num_formatter
  import lcd_num_formatter_pkg::*;
#(
  parameter logic [15:0] LABEL1 = 16'h413A,
  parameter logic [15:0] LABEL2 = 16'h423A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  value_a,
  input  logic [15:0]  value_b,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [127:0] line1,
  output logic [127:0] line2
);

  state_t       state_q, state_d;
  logic         sel_q;
  logic [15:0]  op_a_q, op_b_q;
  logic         neg_q;
  logic [3:0]   cnt_q;
  logic [127:0] buf_a_q, buf_b_q;
  logic         load, step;
  logic [15:0]  op_sel, mag;
  logic [19:0]  bcd;

  assign op_sel = sel_q ? op_b_q : op_a_q;
  // Unsigned 16-bit result, so -32768 maps to 32768 without overflow.
  assign mag    = op_sel[15] ? (~op_sel + 16'd1) : op_sel;

  bcd_dabble16 u_dabble (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .bin  (mag),
    .bcd  (bcd)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == 4'd15) state_d = FORMAT;
      end
      FORMAT: state_d = sel_q ? COMMIT : LOAD;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      buf_a_q <= {LINE_CHARS{SPACE}};
      buf_b_q <= {LINE_CHARS{SPACE}};
      busy    <= 1'b0;
      done    <= 1'b0;
      line1   <= {LINE_CHARS{SPACE}};
      line2   <= {LINE_CHARS{SPACE}};
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a_q <= value_a;
            op_b_q <= value_b;
            sel_q  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          neg_q <= op_sel[15];
          cnt_q <= '0;
        end
        SHIFT: cnt_q <= cnt_q + 4'd1;
        FORMAT: begin
          if (!sel_q) begin
            buf_a_q <= format_line(LABEL1, neg_q, bcd);
            sel_q   <= 1'b1;
          end else begin
            buf_b_q <= format_line(LABEL2, neg_q, bcd);
          end
        end
        COMMIT: begin
          line1 <= buf_a_q;
          line2 <= buf_b_q;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Randomized self-checking bench for lcd_num_formatter against a decimal-string model.
module tb_lcd_num_formatter;

  localparam logic [15:0]  LBL_A  = 16'h413A;
  localparam logic [15:0]  LBL_B  = 16'h423A;
  localparam logic [127:0] BLANKS = {16{8'h20}};

  logic         clk, rst, start;
  logic [15:0]  value_a, value_b;
  logic         busy, done;
  logic [127:0] line1, line2;

  int total = 0;
  int bad   = 0;

  lcd_num_formatter dut (
    .clk     (clk),
    .rst     (rst),
    .value_a (value_a),
    .value_b (value_b),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .line1   (line1),
    .line2   (line2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: print the signed value in decimal, right-aligned into five digit slots.
  function automatic logic [127:0] expect_line(input logic [15:0] label, input logic [15:0] raw);
    logic [127:0] l;
    logic [7:0]   c [16];
    int           v, m;
    v = int'($signed(raw));
    m = (v < 0) ? -v : v;
    for (int i = 0; i < 16; i++) c[i] = 8'h20;
    c[0] = label[15:8];
    c[1] = label[7:0];
    c[2] = (v < 0) ? 8'h2D : 8'h20;
    for (int i = 7; i >= 3; i--) begin
      if (i == 7 || m > 0) c[i] = 8'h30 + 8'(m % 10);
      m = m / 10;
    end
    for (int i = 0; i < 16; i++) l[127-8*i -: 8] = c[i];
    return l;
  endfunction

  task automatic run_conv(input logic [15:0] a, input logic [15:0] b, input bit disturb,
                          input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    value_a = a;
    value_b = b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy"}, {127'd0, busy}, 128'd1);
    start = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (disturb) begin
        start   = 1'($urandom_range(0, 1));
        value_a = 16'($urandom);
        value_b = 16'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_latency"}, 128'(cyc), 128'd37);
    check({tag, "_line1"}, line1, expect_line(LBL_A, a));
    check({tag, "_line2"}, line2, expect_line(LBL_B, b));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
    check({tag, "_idle"}, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int extra;
    logic [127:0] s;
    rst     = 1'b1;
    start   = 1'b0;
    value_a = '0;
    value_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_line1", line1, BLANKS);
    check("rst_line2", line2, BLANKS);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    run_conv(16'd1234, 16'd0, 1'b0, "dir1234");
    s = "A:  1234        ";
    check("dir1234_text", line1, s);
    run_conv(16'h8000, 16'h7FFF, 1'b0, "dirext");
    s = "A:-32768        ";
    check("dirext_text1", line1, s);
    s = "B: 32767        ";
    check("dirext_text2", line2, s);
    run_conv(16'hFFFB, 16'd10, 1'b0, "dirneg5");
    s = "A:-    5        ";
    check("dirneg5_text1", line1, s);
    s = "B:    10        ";
    check("dirneg5_text2", line2, s);

    run_conv(16'd4321, 16'hFF85, 1'b1, "disturb");

    // Lines must hold their previous contents while idle.
    repeat (5) @(posedge clk);
    #1;
    check("hold_line1", line1, expect_line(LBL_A, 16'd4321));

    // Abort mid-conversion with reset.
    @(negedge clk);
    value_a = 16'd999;
    value_b = 16'hD8F1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_line1", line1, BLANKS);
    check("abort_line2", line2, BLANKS);
    check("abort_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    rst   = 1'b0;
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("abort_no_done", 128'(extra), 128'd0);
    check("abort_lines_kept", line1, BLANKS);
    run_conv(16'd31, 16'd7, 1'b0, "after_rst");

    for (int n = 0; n < 1000; n++) begin
      run_conv(16'($urandom), 16'($urandom), 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
